// File: rtl/cordic_pkg.sv
// Shared constants and state encoding for the CORDIC sweep controller.
package cordic_pkg;

  localparam logic [15:0] ONE     = 16'h4000;  // 1.0 in Q2.14
  localparam int unsigned DEG_MOD = 360;       // degrees per revolution
  localparam logic [7:0]  U8_MID  = 8'h80;     // offset-binary zero

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_CLR  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_CONVERT   = 3'd4,
    S_HOLD      = 3'd5
  } state_t;

endpackage

// File: rtl/q214_to_u8.sv
// Signed Q2.14 to 8-bit offset binary: floor shift by 7, saturate, add midscale.
module q214_to_u8
  import cordic_pkg::*;
(
  input  logic [15:0] q_in,
  output logic [7:0]  u8_c
);

  logic signed [15:0] shifted;

  // Saturating shift; adding 128 to an in-range byte is an MSB flip
  always_comb begin
    shifted = $signed(q_in) >>> 7;
    if (shifted > 16'sd127) begin
      u8_c = 8'hFF;
    end else if (shifted < -16'sd128) begin
      u8_c = 8'h00;
    end else begin
      u8_c = shifted[7:0] ^ U8_MID;
    end
  end

endmodule

// File: rtl/cordic_sweep_ctrl.sv
// Angle sweep sequencer around cordic_sin_cos with sample conversion and valid/ready output.
module cordic_sweep_ctrl
  import cordic_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 63,
  parameter int unsigned ANGLE_MAX      = DEG_MOD - 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [8:0]  step,
  input  logic        out_ready,
  input  logic [15:0] cordic_sine,
  input  logic [15:0] cordic_cosine,
  input  logic        cordic_done,
  output logic        cordic_start,
  output logic [15:0] cordic_angle,
  output logic        out_valid,
  output logic [7:0]  sin_u8,
  output logic [7:0]  cos_u8,
  output logic [8:0]  cur_angle,
  output logic        timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [8:0]       ANG_MAX_9 = 9'(ANGLE_MAX);
  localparam logic [9:0]       MOD_10    = 10'(ANGLE_MAX + 1);

  state_t           state_q, state_d;
  logic [8:0]       angle_q, angle_d;
  logic [8:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      sin_raw_q, sin_raw_d;
  logic [15:0]      cos_raw_q, cos_raw_d;
  logic             start_q, start_d;
  logic [15:0]      cangle_q, cangle_d;
  logic             valid_q, valid_d;
  logic [7:0]       sin_q, sin_d;
  logic [7:0]       cos_q, cos_d;
  logic [8:0]       cur_q, cur_d;
  logic             err_q, err_d;

  logic [9:0]       sum;
  logic [CNT_W-1:0] cnt_inc;
  logic [7:0]       sin_cv_c;
  logic [7:0]       cos_cv_c;

  q214_to_u8 u_sin_cv (.q_in(sin_raw_q), .u8_c(sin_cv_c));
  q214_to_u8 u_cos_cv (.q_in(cos_raw_q), .u8_c(cos_cv_c));

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d   = state_q;
    angle_d   = angle_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    sin_raw_d = sin_raw_q;
    cos_raw_d = cos_raw_q;
    start_d   = start_q;
    cangle_d  = cangle_q;
    valid_d   = valid_q;
    sin_d     = sin_q;
    cos_d     = cos_q;
    cur_d     = cur_q;
    err_d     = err_q;
    sum       = {1'b0, angle_q} + {1'b0, step_q};
    cnt_inc   = cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        start_d = 1'b0;
        valid_d = 1'b0;
        if (!enable) begin
          err_d = 1'b0;
        end else begin
          if (step == 9'd0) begin
            step_d = 9'd1;
          end else if (step > ANG_MAX_9) begin
            step_d = ANG_MAX_9;
          end else begin
            step_d = step;
          end
          cangle_d = {7'd0, angle_q};
          start_d  = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        cnt_d = cnt_inc;
        if (!cordic_done) begin
          start_d = 1'b0;
          state_d = S_WAIT_DONE;
        end else if (cnt_inc == TMO_LIMIT) begin
          err_d   = 1'b1;
          start_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_inc;
        if (cordic_done) begin
          sin_raw_d = cordic_sine;
          cos_raw_d = cordic_cosine;
          state_d   = S_CONVERT;
        end else if (cnt_inc == TMO_LIMIT) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_CONVERT: begin
        sin_d   = sin_cv_c;
        cos_d   = cos_cv_c;
        cur_d   = angle_q;
        valid_d = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          angle_d = (sum >= MOD_10) ? 9'(sum - MOD_10) : 9'(sum);
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      angle_q   <= 9'd0;
      step_q    <= 9'd1;
      cnt_q     <= '0;
      sin_raw_q <= 16'd0;
      cos_raw_q <= 16'd0;
      start_q   <= 1'b0;
      cangle_q  <= 16'd0;
      valid_q   <= 1'b0;
      sin_q     <= U8_MID;
      cos_q     <= U8_MID;
      cur_q     <= 9'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      angle_q   <= angle_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      sin_raw_q <= sin_raw_d;
      cos_raw_q <= cos_raw_d;
      start_q   <= start_d;
      cangle_q  <= cangle_d;
      valid_q   <= valid_d;
      sin_q     <= sin_d;
      cos_q     <= cos_d;
      cur_q     <= cur_d;
      err_q     <= err_d;
    end
  end

  assign cordic_start = start_q;
  assign cordic_angle = cangle_q;
  assign out_valid    = valid_q;
  assign sin_u8       = sin_q;
  assign cos_u8       = cos_q;
  assign cur_angle    = cur_q;
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_cordic_sweep_ctrl.sv
// Scoreboard bench for cordic_sweep_ctrl with a behavioural CORDIC model.
`timescale 1ns/1ps
module tb_cordic_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [8:0]  step = 9'd1;
  logic        out_ready = 1'b0;
  logic [15:0] cordic_sine = 16'd0;
  logic [15:0] cordic_cosine = 16'd0;
  logic        cordic_done = 1'b1;
  logic        cordic_start;
  logic [15:0] cordic_angle;
  logic        out_valid;
  logic [7:0]  sin_u8;
  logic [7:0]  cos_u8;
  logic [8:0]  cur_angle;
  logic        timeout_err;

  always #5 clk = ~clk;

  cordic_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .step(step), .out_ready(out_ready),
    .cordic_sine(cordic_sine), .cordic_cosine(cordic_cosine), .cordic_done(cordic_done),
    .cordic_start(cordic_start), .cordic_angle(cordic_angle), .out_valid(out_valid),
    .sin_u8(sin_u8), .cos_u8(cos_u8), .cur_angle(cur_angle), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [8:0] ang;
    logic [7:0] s;
    logic [7:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   rx_count = 0;
  int   start_count = 0;
  int   angle_model = 0;
  bit   hang = 1'b0;
  logic mon_start_prev = 1'b0;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  // CORDIC stimulus values {sine, cosine} per angle, Q2.14
  function automatic logic [31:0] model_sc(input logic [8:0] a);
    case (a)
      9'd0:    return {16'h0000, 16'h4000};
      9'd90:   return {16'h4000, 16'h0000};
      9'd180:  return {16'h0000, 16'hC006};
      9'd270:  return {16'hC000, 16'h0000};
      default: return (a < 9'd180) ? {16'h3F80, 16'h007F} : {16'hFFFF, 16'h8000};
    endcase
  endfunction

  // Hand-computed offset-binary results for the values above
  function automatic exp_t exp_for(input int a);
    exp_t e;
    e.ang = 9'(a);
    case (a)
      0:       begin e.s = 8'h80; e.c = 8'hFF; end
      90:      begin e.s = 8'hFF; e.c = 8'h80; end
      180:     begin e.s = 8'h80; e.c = 8'h00; end
      270:     begin e.s = 8'h00; e.c = 8'h80; end
      default: begin
        if (a < 180) begin e.s = 8'hFF; e.c = 8'h80; end
        else         begin e.s = 8'h7F; e.c = 8'h00; end
      end
    endcase
    return e;
  endfunction

  // Behavioural CORDIC: done clears on start, sets 33 cycles later
  logic       m_prev = 1'b0;
  int         m_cnt = 0;
  logic [8:0] m_ang = 9'd0;
  always @(posedge clk) begin
    m_prev <= cordic_start;
    if (cordic_start && !m_prev) begin
      cordic_done <= 1'b0;
      m_cnt       <= hang ? 0 : 33;
      m_ang       <= cordic_angle[8:0];
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        cordic_done <= 1'b1;
        {cordic_sine, cordic_cosine} <= model_sc(m_ang);
      end
    end
  end

  // Monitor: counts start pulses, checks each transferred sample against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (cordic_start && !mon_start_prev) start_count++;
      mon_start_prev = cordic_start;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_sample", exp_q.size(), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("cur_angle", int'(cur_angle), int'(e.ang));
          chk("sin_u8", int'(sin_u8), int'(e.s));
          chk("cos_u8", int'(cos_u8), int'(e.c));
        end
        rx_count++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_start"}, int'(cordic_start), 0);
    chk({tag, "_angle"}, int'(cordic_angle), 0);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_sin"}, int'(sin_u8), 'h80);
    chk({tag, "_cos"}, int'(cos_u8), 'h80);
    chk({tag, "_cur"}, int'(cur_angle), 0);
    chk({tag, "_err"}, int'(timeout_err), 0);
  endtask

  // Run n conversions, dropping enable while the last one is in flight
  task automatic run_sweep(input int n, input int stp);
    int s0, r0, eff, k, s1;
    s0 = start_count;
    r0 = rx_count;
    eff = (stp == 0) ? 1 : ((stp > 359) ? 359 : stp);
    step = 9'(stp);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_for(angle_model));
      angle_model = (angle_model + eff) % 360;
    end
    out_ready = 1'b1;
    enable = 1'b1;
    k = 0;
    while (start_count < s0 + n && k < 1000) begin tick(); k++; end
    chk("start_count", start_count, s0 + n);
    repeat (5) tick();
    enable = 1'b0;
    k = 0;
    while (rx_count < r0 + n && k < 300) begin tick(); k++; end
    chk("rx_count", rx_count, r0 + n);
    s1 = start_count;
    repeat (80) tick();
    chk("no_start_after_disable", start_count, s1);
  endtask

  task automatic backpressure();
    int k, s1, r0;
    logic [7:0] hs, hc;
    logic [8:0] ha;
    r0 = rx_count;
    exp_q.push_back(exp_for(angle_model));
    angle_model = (angle_model + 90) % 360;
    step = 9'd90;
    out_ready = 1'b0;
    enable = 1'b1;
    k = 0;
    while (!out_valid && k < 200) begin tick(); k++; end
    chk("bp_valid_seen", int'(out_valid), 1);
    enable = 1'b0;
    hs = sin_u8; hc = cos_u8; ha = cur_angle;
    s1 = start_count;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_hold", int'({out_valid, sin_u8, cos_u8, cur_angle}), int'({1'b1, hs, hc, ha}));
    end
    chk("bp_no_start", start_count, s1);
    chk("bp_no_transfer", rx_count, r0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_valid_drop", int'(out_valid), 0);
    chk("bp_sample_kept", int'({sin_u8, cos_u8, cur_angle}), int'({hs, hc, ha}));
    repeat (5) tick();
    chk("bp_one_transfer", rx_count, r0 + 1);
  endtask

  task automatic timeout_test();
    int k, n;
    hang = 1'b1;
    out_ready = 1'b1;
    enable = 1'b1;
    k = 0;
    while (!cordic_start && k < 50) begin tick(); k++; end
    chk("tmo_start_seen", int'(cordic_start), 1);
    n = 0;
    while (!timeout_err && n < 200) begin tick(); n++; end
    chk("tmo_cycles", n, 64);
    chk("tmo_err_set", int'(timeout_err), 1);
    chk("tmo_start_low", int'(cordic_start), 0);
    chk("tmo_valid_low", int'(out_valid), 0);
    chk("tmo_angle", int'(cordic_angle), angle_model);
    enable = 1'b0;
    tick();
    chk("tmo_err_clear", int'(timeout_err), 0);
    hang = 1'b0;
    repeat (3) tick();
  endtask

  task automatic reset_mid_conversion();
    int k;
    step = 9'd1;
    enable = 1'b1;
    k = 0;
    while (!cordic_start && k < 50) begin tick(); k++; end
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    angle_model = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    step = 9'd90;
    repeat (3) tick();
    check_reset("reset");
    enable = 1'b0;
    rst_n = 1'b1;
    tick();

    run_sweep(5, 90);        // 0, 90, 180, 270, wrap to 0
    backpressure();          // sample at 90 held for 20 cycles
    timeout_test();          // hung CORDIC at 180
    run_sweep(3, 0);         // 180, 181, 182
    reset_mid_conversion();
    run_sweep(3, 400);       // 0, 359, 358

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
